// File: rtl/bus_load_latch.sv
// Bus receiver: samples the shared tristate bus after a settle cycle, loads one of four
// operand registers and runs a four-phase ack. Optional flag capture: BUS_LOAD_FLAGS_EN.
module bus_load_latch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  input  logic             bus_valid_n,
  input  logic [1:0]       dst_sel,
  input  logic             cout_in,
  output logic             ack,
  output logic             busy,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] reg_c,
  output logic [WIDTH-1:0] reg_d,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic [7:0]       xfer_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       write_en;
  logic [7:0] count_q, count_d;

  // The bus is only looked at in CAPTURE; IDLE is the settle cycle.
  always_comb begin
    state_d  = state_q;
    write_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus_valid_n) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!bus_valid_n) begin
          write_en = 1'b1;
          state_d  = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (bus_valid_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign busy = (state_q != IDLE);
  assign ack  = (state_q == ACK);

  logic [WIDTH-1:0] regs_out [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_operand
    logic [WIDTH-1:0] reg_q, reg_d;

    always_comb begin
      reg_d = reg_q;
      if (write_en && (dst_sel == 2'(gi))) reg_d = bus;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) reg_q <= '0;
      else        reg_q <= reg_d;
    end

    assign regs_out[gi] = reg_q;
  end

  assign reg_a = regs_out[0];
  assign reg_b = regs_out[1];
  assign reg_c = regs_out[2];
  assign reg_d = regs_out[3];

  always_comb begin
    count_d = count_q;
    if (write_en) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 8'd0;
    else        count_q <= count_d;
  end

  assign xfer_count = count_q;

`ifdef BUS_LOAD_FLAGS_EN
  logic flag_carry_q, flag_carry_d;
  logic flag_zero_q, flag_zero_d;

  always_comb begin
    flag_carry_d = flag_carry_q;
    flag_zero_d  = flag_zero_q;
    if (write_en) begin
      flag_carry_d = cout_in;
      flag_zero_d  = (bus == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
    end else begin
      flag_carry_q <= flag_carry_d;
      flag_zero_q  <= flag_zero_d;
    end
  end

  assign flag_carry = flag_carry_q;
  assign flag_zero  = flag_zero_q;
`else
  // Carry input has no destination when flag capture is left out.
  logic unused_cout;
  assign unused_cout = cout_in;
  assign flag_carry  = 1'b0;
  assign flag_zero   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_load_latch.sv
// Scoreboard bench for bus_load_latch: transfers push expected register/flag/count
// snapshots; a monitor compares them on every rising ack.
module tb_bus_load_latch;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] bus = '0;
  logic             bus_valid_n = 1'b1;
  logic [1:0]       dst_sel = 2'd0;
  logic             cout_in = 1'b0;
  logic             ack, busy, flag_carry, flag_zero;
  logic [WIDTH-1:0] reg_a, reg_b, reg_c, reg_d;
  logic [7:0]       xfer_count;

  bus_load_latch #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .bus_valid_n(bus_valid_n),
    .dst_sel(dst_sel), .cout_in(cout_in), .ack(ack), .busy(busy),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
    .flag_carry(flag_carry), .flag_zero(flag_zero), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic [7:0] a, b, c, d;
    logic       fc, fz;
    logic [7:0] cnt;
  } snap_t;

  snap_t      exp_q[$];
  logic [7:0] m_reg [4];
  logic       m_fc, m_fz;
  logic [7:0] m_cnt;
  bit         wrap_phase = 1'b0;
  int         last_ack_cycle = -1;
  logic       ack_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_fc  = 1'b0;
    m_fz  = 1'b0;
    m_cnt = 8'h00;
  endtask

  task automatic model_write(input logic [7:0] v, input logic [1:0] d, input logic c);
    snap_t s;
    m_reg[d] = v;
`ifdef BUS_LOAD_FLAGS_EN
    m_fc = c;
    m_fz = (v == 8'h00);
`else
    if (c) m_fc = 1'b0;
`endif
    m_cnt = m_cnt + 8'd1;
    s.a = m_reg[0]; s.b = m_reg[1]; s.c = m_reg[2]; s.d = m_reg[3];
    s.fc = m_fc; s.fz = m_fz; s.cnt = m_cnt;
    exp_q.push_back(s);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_reg_a"}, 32'(reg_a), 0);
    chk({tag, "_reg_b"}, 32'(reg_b), 0);
    chk({tag, "_reg_c"}, 32'(reg_c), 0);
    chk({tag, "_reg_d"}, 32'(reg_d), 0);
    chk({tag, "_flag_carry"}, 32'(flag_carry), 0);
    chk({tag, "_flag_zero"}, 32'(flag_zero), 0);
    chk({tag, "_xfer_count"}, 32'(xfer_count), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Four-phase driver: raise valid_n once ack is seen, start the next only after ack drops.
  task automatic xfer(input logic [7:0] v, input logic [1:0] d, input logic c);
    int n;
    @(negedge clk);
    bus = v; dst_sel = d; cout_in = c; bus_valid_n = 1'b0;
    model_write(v, d, c);
    n = 0;
    while (!ack && n < 10) begin @(negedge clk); n++; end
    if (!ack) begin
      checks++; failures++;
      $display("FAIL xfer_ack_timeout actual=ack0 required=ack1 value=0x%0h", v);
    end
    bus_valid_n = 1'b1;
    bus = 8'hxx;
    n = 0;
    while (ack && n < 10) begin @(negedge clk); n++; end
    if (ack) begin
      checks++; failures++;
      $display("FAIL xfer_release_timeout actual=ack1 required=ack0 value=0x%0h", v);
    end
  endtask

  // Monitor: every rising ack must match the oldest pending expectation.
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (ack && !ack_prev) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack actual=ack1 required=ack0 cycle=%0d", cycle);
        end else begin
          s = exp_q.pop_front();
          chk("sb_reg_a", 32'(reg_a), 32'(s.a));
          chk("sb_reg_b", 32'(reg_b), 32'(s.b));
          chk("sb_reg_c", 32'(reg_c), 32'(s.c));
          chk("sb_reg_d", 32'(reg_d), 32'(s.d));
          chk("sb_flag_carry", 32'(flag_carry), 32'(s.fc));
          chk("sb_flag_zero", 32'(flag_zero), 32'(s.fz));
          chk("sb_xfer_count", 32'(xfer_count), 32'(s.cnt));
          if (wrap_phase && last_ack_cycle >= 0)
            chk("handshake_period", 32'(cycle - last_ack_cycle), 32'd4);
          last_ack_cycle = cycle;
          $display("xfer cycle=%0d a=%02h b=%02h c=%02h d=%02h fc=%0b fz=%0b cnt=%0d",
                   cycle, reg_a, reg_b, reg_c, reg_d, flag_carry, flag_zero, xfer_count);
        end
      end
      ack_prev = ack;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] iv;
    model_reset();

    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Single transfer: valid_n low for exactly three cycles.
    bus = 8'h5A; dst_sel = 2'd2; cout_in = 1'b1; bus_valid_n = 1'b0;
    model_write(8'h5A, 2'd2, 1'b1);
    @(negedge clk);
    chk("single_settle_ack", 32'(ack), 0);
    chk("single_settle_busy", 32'(busy), 1);
    chk("single_settle_reg_c", 32'(reg_c), 0);
    @(negedge clk);
    chk("single_ack_cycle1", 32'(ack), 1);
    @(negedge clk);
    chk("single_ack_cycle2", 32'(ack), 1);
    bus_valid_n = 1'b1;
    @(negedge clk);
    chk("single_ack_fall", 32'(ack), 0);
    chk("single_busy_fall", 32'(busy), 0);
    chk("single_count", 32'(xfer_count), 1);
    chk("single_reg_c", 32'(reg_c), 32'h5A);

    // Aborted: one low sample only, the driver withdraws in CAPTURE.
    @(negedge clk);
    bus = 8'hEE; dst_sel = 2'd0; cout_in = 1'b0; bus_valid_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 1);
    bus_valid_n = 1'b1;
    @(negedge clk);
    chk("abort_busy_clear", 32'(busy), 0);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_reg_a", 32'(reg_a), 0);
    chk("abort_count", 32'(xfer_count), 1);
    chk("abort_flag_carry", 32'(flag_carry), 32'(m_fc));
    chk("abort_flag_zero", 32'(flag_zero), 32'(m_fz));

    // Flag capture.
    xfer(8'h00, 2'd1, 1'b1);
`ifdef BUS_LOAD_FLAGS_EN
    chk("flags_zero_after_00", 32'(flag_zero), 1);
    chk("flags_carry_after_00", 32'(flag_carry), 1);
`else
    chk("flags_zero_after_00", 32'(flag_zero), 0);
    chk("flags_carry_after_00", 32'(flag_carry), 0);
`endif
    xfer(8'h80, 2'd3, 1'b0);
    chk("flags_zero_after_80", 32'(flag_zero), 0);
    chk("flags_carry_after_80", 32'(flag_carry), 0);
    chk("flags_reg_d", 32'(reg_d), 32'h80);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // 256 back-to-back transfers wrap the counter.
    wrap_phase = 1'b1;
    last_ack_cycle = -1;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      xfer(iv, 2'd0, iv[0]);
    end
    wrap_phase = 1'b0;
    chk("wrap_reg_a", 32'(reg_a), 32'hFF);
    chk("wrap_count", 32'(xfer_count), 0);

    // Reset while acknowledging, valid_n held low through release.
    @(negedge clk);
    bus = 8'h33; dst_sel = 2'd0; cout_in = 1'b1; bus_valid_n = 1'b0;
    model_write(8'h33, 2'd0, 1'b1);
    n = 0;
    while (!ack && n < 10) begin @(negedge clk); n++; end
    chk("rst_ack_reached", 32'(ack), 1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_in_ack");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_write(8'h33, 2'd0, 1'b1);
    @(posedge clk);
    #1 chk("rst_release_edge1_reg_a", 32'(reg_a), 0);
    @(posedge clk);
    #1 chk("rst_release_edge2_reg_a", 32'(reg_a), 32'h33);
    chk("rst_release_ack", 32'(ack), 1);
    chk("rst_release_count", 32'(xfer_count), 1);
    @(negedge clk);
    bus_valid_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
